// File: rtl/fft_pkg.sv
// Shared constants, bin type, ping-pong fill state and bit-reverse helper for the FFT output serializer.
package fft_pkg;

    localparam int N_POINTS = 32;
    localparam int IDX_W    = 5;
    localparam int OUT_W    = 32;

    typedef logic signed [OUT_W-1:0] bin_t;

    // Encoding equals the number of full banks.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } fill_state_t;

    function automatic logic [IDX_W-1:0] bitrev5(input logic [IDX_W-1:0] b);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = b[IDX_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of N_POINTS bins: parallel write of a whole frame, single combinational read port.
// Latency: write visible the cycle after we; read is combinational from the stored registers.
// Backpressure: none, the caller decides when to write.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                        CLK_50,
    input  logic                        RST,
    input  logic                        we,
    input  logic [N_POINTS*OUT_W-1:0]   wdata,
    input  logic [IDX_W-1:0]            raddr,
    output logic signed [OUT_W-1:0]     rdata
);

    bin_t mem [N_POINTS];

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            for (int i = 0; i < N_POINTS; i++) mem[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < N_POINTS; i++) mem[i] <= wdata[i*OUT_W +: OUT_W];
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_serializer.sv
// Captures a 32-bin FFT frame and streams it one bin per cycle; FFT_SER_BITREV_EN selects bit-reversed order.
// Latency: bin 0 is valid the cycle after the accepting edge; 1 beat/cycle while out_ready is high.
// Backpressure: two-bank ping-pong absorbs one extra frame; strobes with both banks full are dropped and flag overflow.
module fft_out_serializer
    import fft_pkg::*;
(
    input  logic                    CLK_50,
    input  logic                    RST,
    input  logic                    frame_valid,
    input  logic signed [OUT_W-1:0] X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    input  logic signed [OUT_W-1:0] X8,  X9,  X10, X11, X12, X13, X14, X15,
    input  logic signed [OUT_W-1:0] X16, X17, X18, X19, X20, X21, X22, X23,
    input  logic signed [OUT_W-1:0] X24, X25, X26, X27, X28, X29, X30, X31,
    output logic                    frame_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    overflow
);

    fill_state_t                state, state_nxt;
    logic                       wr_sel, rd_sel;
    logic [IDX_W-1:0]           beat, rd_idx;
    logic [N_POINTS*OUT_W-1:0]  frame_flat;
    bin_t                       rdata0, rdata1;
    logic                       accept, xfer, fin;

    assign frame_flat = {X31, X30, X29, X28, X27, X26, X25, X24,
                         X23, X22, X21, X20, X19, X18, X17, X16,
                         X15, X14, X13, X12, X11, X10, X9,  X8,
                         X7,  X6,  X5,  X4,  X3,  X2,  X1,  X0};

`ifdef FFT_SER_BITREV_EN
    assign rd_idx = bitrev5(beat);
`else
    assign rd_idx = beat;
`endif

    assign frame_ready = (state != S_FULL) && !RST;
    assign accept      = frame_valid && frame_ready;
    assign xfer        = out_valid && out_ready;
    assign fin         = xfer && (beat == IDX_W'(N_POINTS - 1));

    fft_frame_bank u_bank0 (
        .CLK_50 (CLK_50),
        .RST    (RST),
        .we     (accept && !wr_sel),
        .wdata  (frame_flat),
        .raddr  (rd_idx),
        .rdata  (rdata0)
    );

    fft_frame_bank u_bank1 (
        .CLK_50 (CLK_50),
        .RST    (RST),
        .we     (accept && wr_sel),
        .wdata  (frame_flat),
        .raddr  (rd_idx),
        .rdata  (rdata1)
    );

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Accept and final beat together keep the fill level; both the swap and the write still happen.
    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (accept)         state_nxt = S_ONE;
            S_ONE:   if (accept && !fin) state_nxt = S_FULL;
                     else if (fin && !accept) state_nxt = S_EMPTY;
            S_FULL:  if (fin)            state_nxt = S_ONE;
            default:                     state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state != S_EMPTY);
        out_last  = out_valid && (beat == IDX_W'(N_POINTS - 1));
        out_idx   = rd_idx;
        out_data  = rd_sel ? rdata1 : rdata0;
    end

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            beat     <= '0;
            rd_sel   <= 1'b0;
            wr_sel   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (accept)                      wr_sel   <= ~wr_sel;
            if (frame_valid && !frame_ready) overflow <= 1'b1;
            if (xfer)                        beat     <= beat + 1'b1;
            if (fin)                         rd_sel   <= ~rd_sel;
        end
    end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer: reset, streaming, stall, overflow, coincident accept, mid-stream reset.
module tb_fft_out_serializer;

    typedef logic signed [31:0] frm_t [32];

    logic               CLK_50 = 1'b0;
    logic               RST = 1'b1;
    logic               frame_valid = 1'b0;
    logic               out_ready = 1'b0;
    frm_t               xin;
    logic               frame_ready, out_valid, out_last, overflow;
    logic signed [31:0] out_data;
    logic [4:0]         out_idx;

    int checks = 0;
    int errors = 0;

    always #5 CLK_50 = ~CLK_50;

    fft_out_serializer dut (
        .CLK_50(CLK_50), .RST(RST), .frame_valid(frame_valid),
        .X0(xin[0]),   .X1(xin[1]),   .X2(xin[2]),   .X3(xin[3]),
        .X4(xin[4]),   .X5(xin[5]),   .X6(xin[6]),   .X7(xin[7]),
        .X8(xin[8]),   .X9(xin[9]),   .X10(xin[10]), .X11(xin[11]),
        .X12(xin[12]), .X13(xin[13]), .X14(xin[14]), .X15(xin[15]),
        .X16(xin[16]), .X17(xin[17]), .X18(xin[18]), .X19(xin[19]),
        .X20(xin[20]), .X21(xin[21]), .X22(xin[22]), .X23(xin[23]),
        .X24(xin[24]), .X25(xin[25]), .X26(xin[26]), .X27(xin[27]),
        .X28(xin[28]), .X29(xin[29]), .X30(xin[30]), .X31(xin[31]),
        .frame_ready(frame_ready), .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .overflow(overflow)
    );

    function automatic int ord(input int b);
        logic [4:0] v, r;
        v = 5'(b);
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
`ifdef FFT_SER_BITREV_EN
        return int'(r);
`else
        return int'(v);
`endif
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_50);
        #1;
    endtask

    task automatic strobe(input frm_t f);
        xin = f;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    // Checks beats first..first+n-1 of frame f with out_ready assumed high.
    task automatic stream(input string tag, input frm_t f, input int first, input int n);
        for (int b = first; b < first + n; b++) begin
            chk($sformatf("%s_vld%0d", tag, b), 64'(out_valid), 64'(1));
            chk($sformatf("%s_idx%0d", tag, b), 64'(out_idx), 64'(ord(b)));
            chk($sformatf("%s_dat%0d", tag, b), 64'(out_data), 64'(f[ord(b)]));
            chk($sformatf("%s_last%0d", tag, b), 64'(out_last), 64'(b == 31));
            tick();
        end
    endtask

    frm_t f1, f2, fa, fb, fc, fd, fe;

    initial begin
        for (int k = 0; k < 32; k++) begin
            f1[k] = k * 1000 - 5;
            f2[k] = k * 7 + 100;
            fa[k] = k + 2000;
            fb[k] = -k * 3 - 1;
            fc[k] = 12345;
            fd[k] = k;
            fe[k] = 32'sh7000_0000 + k;
            xin[k] = '0;
        end

        // Reset state.
        tick();
        tick();
        chk("rst_vld", 64'(out_valid), 64'(0));
        chk("rst_last", 64'(out_last), 64'(0));
        chk("rst_dat", 64'(out_data), 64'(0));
        chk("rst_idx", 64'(out_idx), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_frdy", 64'(frame_ready), 64'(0));
        RST = 1'b0;
        #1;
        chk("post_rst_frdy", 64'(frame_ready), 64'(1));

        // One frame, out_ready high: 32 consecutive beats then idle.
        out_ready = 1'b1;
        strobe(f1);
        stream("f1", f1, 0, 32);
        chk("f1_idle_vld", 64'(out_valid), 64'(0));
        chk("f1_idle_last", 64'(out_last), 64'(0));

        // Stall 10 cycles holding beat 7.
        strobe(f2);
        stream("f2a", f2, 0, 7);
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("stall_idx%0d", c), 64'(out_idx), 64'(ord(7)));
            chk($sformatf("stall_dat%0d", c), 64'(out_data), 64'(f2[ord(7)]));
            chk($sformatf("stall_vld%0d", c), 64'(out_valid), 64'(1));
            tick();
        end
        out_ready = 1'b1;
        stream("f2b", f2, 7, 25);
        chk("f2_idle_vld", 64'(out_valid), 64'(0));

        // Two frames absorbed, third dropped.
        out_ready = 1'b0;
        strobe(fa);
        chk("ovf_frdy1", 64'(frame_ready), 64'(1));
        strobe(fb);
        chk("ovf_frdy0", 64'(frame_ready), 64'(0));
        strobe(fc);
        chk("ovf_set", 64'(overflow), 64'(1));
        chk("ovf_frdy_still0", 64'(frame_ready), 64'(0));
        out_ready = 1'b1;
        stream("fa", fa, 0, 32);
        stream("fb", fb, 0, 32);
        chk("ovf_idle_vld", 64'(out_valid), 64'(0));
        chk("ovf_sticky", 64'(overflow), 64'(1));

        // Strobe coinciding with the final beat at count 1.
        strobe(fd);
        stream("fd", fd, 0, 31);
        chk("coin_last", 64'(out_last), 64'(1));
        chk("coin_frdy", 64'(frame_ready), 64'(1));
        strobe(fe);
        stream("fe", fe, 0, 32);
        chk("coin_idle_vld", 64'(out_valid), 64'(0));

        // Reset at beat 12 with a second frame buffered.
        out_ready = 1'b0;
        strobe(fa);
        strobe(fb);
        out_ready = 1'b1;
        stream("rsm", fa, 0, 12);
        RST = 1'b1;
        tick();
        chk("rsm_vld", 64'(out_valid), 64'(0));
        chk("rsm_frdy_in_rst", 64'(frame_ready), 64'(0));
        chk("rsm_ovf", 64'(overflow), 64'(0));
        chk("rsm_idx", 64'(out_idx), 64'(0));
        chk("rsm_dat", 64'(out_data), 64'(0));
        RST = 1'b0;
        #1;
        chk("rsm_frdy", 64'(frame_ready), 64'(1));
        tick();
        tick();
        chk("rsm_still_idle", 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_out_serializer.md
# fft_out_serializer

Output-side counterpart of the 32-point FFT `Top`. It captures one full frame of 32 parallel signed results (X0..X31) on a frame strobe and streams them out one bin per cycle over a valid/ready interface. It sits between the FFT output registers and the downstream sample sink or checker, in the `CLK_50` domain. A two-frame ping-pong buffer absorbs one frame of backpressure, and an overflow flag records dropped frames.

## Interface
- `N_POINTS`, 32: bins per frame; fixed at 32, so the index is 5 bits.
- `OUT_W`, 32: width of each signed FFT result.
- `CLK_50` in 1: the single clock; all logic is on its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `frame_valid` in 1: one-cycle strobe; X0..X31 hold a complete frame this cycle.
- `X0`..`X31` in `OUT_W` each, signed: parallel FFT results; bin k arrives on Xk.
- `frame_ready` out 1: the buffer can accept a frame this cycle.
- `out_data` out `OUT_W`, signed: the current bin value.
- `out_idx` out 5: natural bin index of `out_data`.
- `out_valid` out 1: `out_data`, `out_idx` and `out_last` are valid.
- `out_last` out 1: the current beat is the final beat of the frame.
- `out_ready` in 1: the sink accepts the beat when `out_valid & out_ready`.
- `overflow` out 1: sticky; set when a frame is strobed while `frame_ready` is 0.

## Operation
- Storage: two banks of 32 x `OUT_W` registers. Control state:
  - `wr_sel`: bank that receives the next frame.
  - `rd_sel`: bank being streamed.
  - `count` (0..2): number of full banks.
  - `beat` (5 bits): stream position within the frame.
- Accept: when `frame_valid & frame_ready`, all 32 inputs are latched into bank `wr_sel`; then `wr_sel` toggles and `count` increments.
- `frame_ready` = (`count` < 2) & !`RST`. There is no same-cycle pass-through: with `count` = 2, a strobe is refused even if the final beat drains in the same cycle.
- Drop: `frame_valid` while `frame_ready` = 0 leaves the banks untouched and sets `overflow`. Only `RST` clears `overflow`.
- Stream:
  - `out_valid` = (`count` > 0).
  - `out_data` = bank[`rd_sel`][`order(beat)`].
  - `out_idx` = `order(beat)`.
  - `out_last` = `out_valid` & (`beat` == 31).
- Transfer: on `out_valid & out_ready`, `beat` increments.
  - At `beat` == 31, `beat` wraps to 0, `rd_sel` toggles and `count` decrements.
  - If that final beat coincides with an accept, `count` is unchanged and both the bank swap and the new write take effect.
- Output stability: while `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_idx` and `out_last` hold their values.
- Width: values pass through bit-exact; there is no rounding or truncation.
- State machine (derived from `count`):
  - EMPTY (0): EMPTY→ONE on accept.
  - ONE (1): ONE→FULL on accept without a final beat; ONE→EMPTY on a final beat without an accept; ONE→ONE on both together.
  - FULL (2): FULL→ONE on a final beat.
- Reset mid-stream: the partial frame and the buffered frame are discarded. `beat`, `count`, `rd_sel` and `wr_sel` go to 0, and no further beats are emitted.

## Timing
- Reset values:
  - `count` 0, `beat` 0, selects 0, all bank registers 0, `overflow` 0.
  - `out_valid` 0, `out_last` 0, `out_data` 0, `out_idx` 0.
  - `frame_ready` is 0 during `RST` and 1 on the first cycle after it.
- Latency: a frame accepted at edge k into an empty buffer gives `out_valid` = 1 with bin 0 in the cycle after edge k.
- Throughput: 32 beats per frame at 1 beat per cycle with `out_ready` held high.
  - Sustained input rate is at most 1 frame per 32 `CLK_50` cycles.
  - A burst of 2 frames is absorbed.
- Combinational paths: there is no path from any input to any output except `RST` → `frame_ready`. The outputs are muxes of registered state only.

## Configuration
- `FFT_SER_BITREV_EN` defined: `order(beat)` is the 5-bit bit-reverse of `beat`, so the stream order is 0, 16, 8, 24, 4, … 31. `out_idx` still reports the natural bin number.
- `FFT_SER_BITREV_EN` undefined: `order(beat)` = `beat`, giving natural order 0..31.

## Structure
- `fft_pkg` holds:
  - the constants `N_POINTS` = 32, `IDX_W` = 5 and `OUT_W` = 32;
  - a `bin_t` signed typedef;
  - the `bitrev5` function.
- Sub-module `fft_frame_bank` is one 32-entry register bank with a write-enable and a 5-bit read port. It is instantiated twice, and the top does the ping-pong control.

## Test plan
- Reset, then one frame Xk = k*1000 - 5, with `out_ready` high:
  - 32 consecutive beats, values -5, 995, … 30995, `out_idx` 0..31;
  - `out_last` only on `out_idx` 31;
  - `out_valid` drops afterwards.
- `out_ready` held low for 10 cycles mid-frame, at beat 7: `out_data`/`out_idx` stay at bin 7 throughout, and streaming then resumes with bin 8.
- Three back-to-back strobes 1 cycle apart with `out_ready` low:
  - the first two are accepted and `frame_ready` goes to 0;
  - the third is dropped and `overflow` goes to 1;
  - 64 beats of frames 1 and 2 follow in order, with `overflow` still 1.
- With `count` = 1, a strobe coincides with the final beat: it is accepted, `count` stays 1, and the new frame's bin 0 appears on the next cycle.
- `RST` asserted at beat 12 with a second frame buffered: `out_valid` goes to 0 the next cycle, and `frame_ready` = 1 after `RST` deasserts.
- With `FFT_SER_BITREV_EN` defined, Xk = k: the `out_data` sequence is 0, 16, 8, 24, 4, 20, …, 31 and `out_idx` equals `out_data` on every beat.
